// File: rtl/stimulus_sequencer_if.sv
// Bundle of the DUT-drive bus and the {pattern,response} record stream of the
// stimulus sequencer; master is the sequencer, slave is the DUT/logger side.
interface stimulus_sequencer_if #(
    parameter int IN_W  = 1,
    parameter int OUT_W = 1
);
    logic             dut_reset;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             rec_valid;
    logic             rec_ready;
    logic [IN_W-1:0]  rec_pattern;
    logic [OUT_W-1:0] rec_response;

    modport master (
        output dut_reset, dut_in, rec_valid, rec_pattern, rec_response,
        input  dut_out, rec_ready
    );

    modport slave (
        input  dut_reset, dut_in, rec_valid, rec_pattern, rec_response,
        output dut_out, rec_ready
    );
endinterface

// File: rtl/stimulus_sequencer.sv
// Exhaustive stimulus sweep for one benchmark netlist: pulses the DUT reset, walks every
// input pattern, and streams one {pattern,response} record per pattern on valid/ready.
module stimulus_sequencer #(
    parameter int IN_W    = 1,
    parameter int OUT_W   = 1,
    parameter int SETTLE  = 1,
    parameter int RST_CYC = 2
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    stimulus_sequencer_if.master bus
);

    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam int SC_W = $clog2(SETTLE + 1);
    localparam int PW   = IN_W + 1;
    localparam logic [PW-1:0] LAST_PAT = {1'b0, {IN_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUT_RST,
        S_APPLY,
        S_EMIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [PW-1:0]    pattern_q, pattern_d;
    logic             rec_valid_q, rec_valid_d;
    logic [IN_W-1:0]  rec_pattern_q, rec_pattern_d;
    logic [OUT_W-1:0] rec_response_q, rec_response_d;
    logic             dut_reset_q, busy_q, done_q;

    logic rst_last, settle_last, handshake, last_pattern;

    assign rst_last     = (rst_cnt_q == RC_W'(RST_CYC - 1));
    assign settle_last  = (settle_cnt_q == SC_W'(SETTLE - 1));
    assign handshake    = rec_valid_q && bus.rec_ready;
    assign last_pattern = (pattern_q == LAST_PAT);

    // State register and every registered output; reset outranks abort and start.
    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from values sampled before the edge.
    always_ff @(posedge CK) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rst_cnt_q      <= '0;
            settle_cnt_q   <= '0;
            pattern_q      <= '0;
            rec_valid_q    <= 1'b0;
            rec_pattern_q  <= '0;
            rec_response_q <= '0;
            dut_reset_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            pattern_q      <= pattern_d;
            rec_valid_q    <= rec_valid_d;
            rec_pattern_q  <= rec_pattern_d;
            rec_response_q <= rec_response_d;
            dut_reset_q    <= (state_d == S_DUT_RST);
            busy_q         <= (state_d == S_DUT_RST) || (state_d == S_APPLY) || (state_d == S_EMIT);
            done_q         <= (state_d == S_DONE);
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default at the top of each always_comb, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_DUT_RST;
            S_DUT_RST:      if (rst_last) state_d = S_APPLY;
            S_APPLY:        if (settle_last) state_d = S_EMIT;
            S_EMIT:         if (handshake) state_d = last_pattern ? S_DONE : S_APPLY;
            default:        state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Counters and record datapath.
    always_comb begin
        rst_cnt_d      = rst_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        pattern_d      = pattern_q;
        rec_valid_d    = rec_valid_q;
        rec_pattern_d  = rec_pattern_q;
        rec_response_d = rec_response_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rst_cnt_d = '0;
                    pattern_d = '0;
                end
            end
            S_DUT_RST: begin
                rst_cnt_d    = rst_cnt_q + RC_W'(1);
                settle_cnt_d = '0;
            end
            S_APPLY: begin
                settle_cnt_d = settle_cnt_q + SC_W'(1);
                // The DUT response is captured only on the edge that leaves APPLY.
                if (settle_last) begin
                    rec_response_d = bus.dut_out;
                    rec_pattern_d  = pattern_q[IN_W-1:0];
                    rec_valid_d    = 1'b1;
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    rec_valid_d = 1'b0;
                    if (!last_pattern) begin
                        pattern_d    = pattern_q + PW'(1);
                        settle_cnt_d = '0;
                    end
                end
            end
            default: ;
        endcase
        if (abort) begin
            rst_cnt_d    = '0;
            settle_cnt_d = '0;
            pattern_d    = '0;
            rec_valid_d  = 1'b0;
        end
    end

    assign bus.dut_reset    = dut_reset_q;
    assign bus.dut_in       = pattern_q[IN_W-1:0];
    assign bus.rec_valid    = rec_valid_q;
    assign bus.rec_pattern  = rec_pattern_q;
    assign bus.rec_response = rec_response_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Directed bench: a 1-bit instance (inverter DUT) and a 3-bit instance (loopback or
// forced DUT response, SETTLE=4) exercised by one task per scenario.
module tb_stimulus_sequencer;

    logic CK;
    logic reset_a, start_a, abort_a, busy_a, done_a;
    logic reset_b, start_b, abort_b, busy_b, done_b;
    logic       b_force;
    logic [2:0] b_force_val;

    int checks = 0;
    int errors = 0;

    stimulus_sequencer_if #(.IN_W(1), .OUT_W(1)) bus_a ();
    stimulus_sequencer_if #(.IN_W(3), .OUT_W(3)) bus_b ();

    assign bus_a.dut_out = ~bus_a.dut_in;
    assign bus_b.dut_out = b_force ? b_force_val : bus_b.dut_in;

    stimulus_sequencer #(.IN_W(1), .OUT_W(1), .SETTLE(1), .RST_CYC(2)) u_a (
        .CK(CK), .reset(reset_a), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .bus(bus_a)
    );

    stimulus_sequencer #(.IN_W(3), .OUT_W(3), .SETTLE(4), .RST_CYC(2)) u_b (
        .CK(CK), .reset(reset_b), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Keeps rec_ready high until a record with pattern p is on the bus (bounded).
    task automatic wait_rec(input logic [2:0] p, output bit ok);
        ok = 1'b0;
        bus_b.rec_ready = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (bus_b.rec_valid && bus_b.rec_pattern == p) ok = 1'b1;
        end
    endtask

    // Gathers statistics of one loopback sweep on instance b, started at the previous edge.
    task automatic collect_sweep(input bit pulse_start, output int n_rec,
                                 output int bad_order, output int bad_gap, output bit timed_out);
        int cyc, last;
        cyc = 0; last = 0; n_rec = 0; bad_order = 0; bad_gap = 0;
        while (!done_b && cyc < 300) begin
            start_b = pulse_start && (cyc % 7 == 3);
            tick();
            cyc++;
            if (bus_b.rec_valid) begin
                if (bus_b.rec_pattern !== 3'(n_rec) || bus_b.rec_response !== 3'(n_rec)) bad_order++;
                if (n_rec == 0 ? (cyc != 6) : (cyc - last != 5)) bad_gap++;
                last = cyc;
                n_rec++;
            end
        end
        start_b = 1'b0;
        timed_out = !done_b;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        start_a = 1'b1; start_b = 1'b1;
        tick(); tick();
        start_a = 1'b0; start_b = 1'b0;
        checks++;
        if ({busy_a, done_a, bus_a.dut_reset, bus_a.dut_in, bus_a.rec_valid,
             bus_a.rec_pattern, bus_a.rec_response} !== 7'b0) begin
            errors++;
            $display("FAIL reset_a_outputs: got %b expected 0000000", {busy_a, done_a,
                     bus_a.dut_reset, bus_a.dut_in, bus_a.rec_valid, bus_a.rec_pattern, bus_a.rec_response});
        end
        checks++;
        if ({busy_b, done_b, bus_b.dut_reset, bus_b.dut_in, bus_b.rec_valid,
             bus_b.rec_pattern, bus_b.rec_response} !== 13'b0) begin
            errors++;
            $display("FAIL reset_b_outputs: got %b expected all zero", {busy_b, done_b,
                     bus_b.dut_reset, bus_b.dut_in, bus_b.rec_valid, bus_b.rec_pattern, bus_b.rec_response});
        end
        reset_a = 1'b0; reset_b = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy_a=%b busy_b=%b expected 0 0", busy_a, busy_b);
        end
    endtask

    task automatic test_basic();
        bus_a.rec_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if (bus_a.dut_reset !== 1'b1 || busy_a !== 1'b1 || bus_a.dut_in !== 1'b0) begin
            errors++;
            $display("FAIL t1_rst_cycle1: dut_reset=%b busy=%b dut_in=%b expected 1 1 0",
                     bus_a.dut_reset, busy_a, bus_a.dut_in);
        end
        tick();
        checks++;
        if (bus_a.dut_reset !== 1'b1) begin
            errors++;
            $display("FAIL t1_rst_cycle2: dut_reset=%b expected 1", bus_a.dut_reset);
        end
        tick();
        checks++;
        if (bus_a.dut_reset !== 1'b0 || bus_a.rec_valid !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL t1_rst_release: dut_reset=%b rec_valid=%b busy=%b expected 0 0 1",
                     bus_a.dut_reset, bus_a.rec_valid, busy_a);
        end
        tick();
        checks++;
        if ({bus_a.rec_valid, bus_a.rec_pattern, bus_a.rec_response} !== 3'b101) begin
            errors++;
            $display("FAIL t1_record0: valid,pattern,response=%b expected 101",
                     {bus_a.rec_valid, bus_a.rec_pattern, bus_a.rec_response});
        end
        tick();
        checks++;
        if (bus_a.rec_valid !== 1'b0 || done_a !== 1'b0 || bus_a.dut_in !== 1'b1) begin
            errors++;
            $display("FAIL t1_after_hs0: rec_valid=%b done=%b dut_in=%b expected 0 0 1",
                     bus_a.rec_valid, done_a, bus_a.dut_in);
        end
        tick();
        checks++;
        if ({bus_a.rec_valid, bus_a.rec_pattern, bus_a.rec_response} !== 3'b110) begin
            errors++;
            $display("FAIL t1_record1: valid,pattern,response=%b expected 110",
                     {bus_a.rec_valid, bus_a.rec_pattern, bus_a.rec_response});
        end
        tick();
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || bus_a.rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_done: done=%b busy=%b rec_valid=%b expected 1 0 0",
                     done_a, busy_a, bus_a.rec_valid);
        end
    endtask

    task automatic test_loopback();
        int n, bo, bg;
        bit to;
        bit extra;
        b_force = 1'b0;
        bus_b.rec_ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        collect_sweep(1'b0, n, bo, bg, to);
        checks++;
        if (to || n != 8) begin
            errors++;
            $display("FAIL t2_record_count: records=%0d timeout=%0d expected 8 0", n, to);
        end
        checks++;
        if (bo != 0 || bg != 0) begin
            errors++;
            $display("FAIL t2_order_timing: bad_order=%0d bad_gap=%0d expected 0 0", bo, bg);
        end
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_b.rec_valid) extra = 1'b1;
        end
        checks++;
        if (extra || bus_b.dut_in !== 3'd7 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL t2_done_hold: extra=%0d dut_in=%0d done=%b expected 0 7 1",
                     extra, bus_b.dut_in, done_b);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_rec(3'd1, ok);
        bus_b.rec_ready = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t3_reach_record1: seen=%0d expected 1", ok);
        end
        b_force = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_force_val = (i % 2 == 0) ? 3'b110 : 3'b001;
            tick();
            if ({bus_b.rec_valid, bus_b.rec_pattern, bus_b.rec_response} !== 7'b1_001_001) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL t3_stall_stable: final valid,pattern,response=%b expected 1001001",
                     {bus_b.rec_valid, bus_b.rec_pattern, bus_b.rec_response});
        end
        bus_b.rec_ready = 1'b1;
        tick();
        b_force = 1'b0;
        checks++;
        if (bus_b.rec_valid !== 1'b0 || bus_b.dut_in !== 3'd2) begin
            errors++;
            $display("FAIL t3_release: rec_valid=%b dut_in=%0d expected 0 2", bus_b.rec_valid, bus_b.dut_in);
        end
        for (int i = 0; i < 100 && !done_b; i++) tick();
        checks++;
        if (done_b !== 1'b1) begin
            errors++;
            $display("FAIL t3_finish: done=%b expected 1", done_b);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int cyc;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_rec(3'd1, ok);
        bus_b.rec_ready = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t4_reach_record1: seen=%0d expected 1", ok);
        end
        abort_b = 1'b1; start_b = 1'b1;
        tick();
        abort_b = 1'b0; start_b = 1'b0;
        checks++;
        if ({bus_b.rec_valid, busy_b, done_b, bus_b.dut_reset, bus_b.dut_in} !== 7'b0) begin
            errors++;
            $display("FAIL t4_abort_idle: valid,busy,done,dut_reset,dut_in=%b expected 0000000",
                     {bus_b.rec_valid, busy_b, done_b, bus_b.dut_reset, bus_b.dut_in});
        end
        abort_b = 1'b1; start_b = 1'b1;
        tick();
        abort_b = 1'b0; start_b = 1'b0;
        tick();
        checks++;
        if (busy_b !== 1'b0 || bus_b.dut_reset !== 1'b0 || bus_b.rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL t4_abort_beats_start: busy=%b dut_reset=%b rec_valid=%b expected 0 0 0",
                     busy_b, bus_b.dut_reset, bus_b.rec_valid);
        end
        bus_b.rec_ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checks++;
        if (bus_b.dut_reset !== 1'b1 || bus_b.dut_in !== 3'd0 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL t4_restart: dut_reset=%b dut_in=%0d busy=%b expected 1 0 1",
                     bus_b.dut_reset, bus_b.dut_in, busy_b);
        end
        cyc = 0;
        while (!bus_b.rec_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 6 || bus_b.rec_pattern !== 3'd0) begin
            errors++;
            $display("FAIL t4_first_record: cycles=%0d pattern=%0d expected 6 0", cyc, bus_b.rec_pattern);
        end
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        b_force = 1'b1;
        b_force_val = 3'b110;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_rec(3'd0, ok);
        tick();
        checks++;
        if (!ok || bus_b.dut_in !== 3'd1 || busy_b !== 1'b1 || bus_b.rec_response !== 3'b110) begin
            errors++;
            $display("FAIL t5_pre_reset: seen=%0d dut_in=%0d busy=%b response=%b expected 1 1 1 110",
                     ok, bus_b.dut_in, busy_b, bus_b.rec_response);
        end
        tick();
        reset_b = 1'b1; start_b = 1'b1;
        tick();
        checks++;
        if ({busy_b, done_b, bus_b.dut_reset, bus_b.dut_in, bus_b.rec_valid,
             bus_b.rec_pattern, bus_b.rec_response} !== 13'b0) begin
            errors++;
            $display("FAIL t5_reset_outputs: got %b expected all zero", {busy_b, done_b,
                     bus_b.dut_reset, bus_b.dut_in, bus_b.rec_valid, bus_b.rec_pattern, bus_b.rec_response});
        end
        reset_b = 1'b0; start_b = 1'b0;
        tick();
        checks++;
        if (busy_b !== 1'b0 || bus_b.dut_reset !== 1'b0) begin
            errors++;
            $display("FAIL t5_start_ignored: busy=%b dut_reset=%b expected 0 0", busy_b, bus_b.dut_reset);
        end
        b_force = 1'b0;
    endtask

    task automatic test_start_busy();
        int n, bo, bg;
        bit to;
        bus_b.rec_ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        collect_sweep(1'b1, n, bo, bg, to);
        checks++;
        if (to || n != 8 || bo != 0 || bg != 0) begin
            errors++;
            $display("FAIL t6_busy_start: records=%0d bad_order=%0d bad_gap=%0d timeout=%0d expected 8 0 0 0",
                     n, bo, bg, to);
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checks++;
        if (done_b !== 1'b0 || busy_b !== 1'b1 || bus_b.dut_reset !== 1'b1) begin
            errors++;
            $display("FAIL t6_start_in_done: done=%b busy=%b dut_reset=%b expected 0 1 1",
                     done_b, busy_b, bus_b.dut_reset);
        end
        collect_sweep(1'b0, n, bo, bg, to);
        checks++;
        if (to || n != 8 || bo != 0 || bg != 0) begin
            errors++;
            $display("FAIL t6_second_sweep: records=%0d bad_order=%0d bad_gap=%0d timeout=%0d expected 8 0 0 0",
                     n, bo, bg, to);
        end
    endtask

    initial begin
        reset_a = 1'b1; start_a = 1'b0; abort_a = 1'b0;
        reset_b = 1'b1; start_b = 1'b0; abort_b = 1'b0;
        bus_a.rec_ready = 1'b0;
        bus_b.rec_ready = 1'b0;
        b_force = 1'b0;
        b_force_val = 3'b000;
        test_reset();
        test_basic();
        test_loopback();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
